// File: rtl/alib_rank_symbol_encoder.sv
// alib_rank_symbol_encoder: maps table ranks of incoming bytes to short/long prefix codes and packs them MSB-first.
// Optional ALIB_RANK_ENC_COUNT_EN adds a saturating symbol counter emitted as a trailer word after each block.
`default_nettype none

module alib_rank_symbol_encoder #(
  parameter int OUT_WIDTH  = 32,
  parameter int SHORT_BITS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_data,
  input  logic                 i_data_valid,
  output logic                 o_data_ready,
  input  logic                 i_flush,
  input  logic                 i_rank_done,
  output logic [7:0]           o_query_char,
  input  logic [7:0]           i_query_rank,
  output logic [OUT_WIDTH-1:0] o_word,
  output logic                 o_word_valid,
  input  logic                 i_word_ready,
  output logic [6:0]           o_word_bits,
  output logic                 o_word_last,
  output logic                 o_abort
);

  localparam int         ACC_W     = OUT_WIDTH + 8;
  localparam logic [6:0] OW        = 7'(OUT_WIDTH);
  localparam logic [8:0] SHORT_LIM = 9'(1 << SHORT_BITS);
`ifdef ALIB_RANK_ENC_COUNT_EN
  localparam logic       LAST_ON_PAD = 1'b0;
`else
  localparam logic       LAST_ON_PAD = 1'b1;
`endif

  typedef enum logic [2:0] {
    S_WAIT    = 3'd0,
    S_ACCEPT  = 3'd1,
    S_LOOKUP  = 3'd2,
    S_CAPTURE = 3'd3,
    S_FLUSH   = 3'd4,
    S_TRAILER = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx, acc_base;
  logic [6:0]       fill, fill_nx, fill_base;
  logic             flush_pending, flush_nx;
  logic [7:0]       query_nx;
  logic             abort_nx;
  logic             drop, full, hs, append;

  logic             short_code;
  logic [8:0]       code9, code_left;
  logic [3:0]       code_len;
  logic [ACC_W-1:0] code_al;

`ifdef ALIB_RANK_ENC_COUNT_EN
  logic [31:0] count, count_nx;
  logic [63:0] count_ext;
  assign count_ext = {32'd0, count};
`endif

  assign drop       = (state != S_WAIT) && !i_rank_done;
  assign full       = (fill >= OW);
  assign short_code = ({1'b0, i_query_rank} < SHORT_LIM);
  // Short codes have a zero prefix and the rank's upper bits are already zero.
  assign code9      = {~short_code, i_query_rank};
  assign code_len   = short_code ? 4'(SHORT_BITS + 1) : 4'd9;
  assign code_left  = code9 << (4'd9 - code_len);
  assign code_al    = {code_left, {(ACC_W-9){1'b0}}};

  always_comb begin
    o_word       = acc[ACC_W-1 -: OUT_WIDTH];
    o_word_valid = 1'b0;
    o_word_bits  = 7'd0;
    o_word_last  = 1'b0;
    o_data_ready = 1'b0;
    state_nx     = state;
    flush_nx     = flush_pending | i_flush;
    query_nx     = o_query_char;
    abort_nx     = 1'b0;
    append       = 1'b0;
`ifdef ALIB_RANK_ENC_COUNT_EN
    count_nx     = count;
`endif

    case (state)
      S_ACCEPT, S_LOOKUP, S_CAPTURE: begin
        if (full) begin
          o_word_valid = 1'b1;
          o_word_bits  = OW;
        end
      end
      S_FLUSH: begin
        o_word_valid = 1'b1;
        if (full) begin
          o_word_bits = OW;
        end else begin
          o_word_bits = fill;
          o_word_last = LAST_ON_PAD;
        end
      end
`ifdef ALIB_RANK_ENC_COUNT_EN
      S_TRAILER: begin
        o_word_valid = 1'b1;
        o_word_bits  = OW;
        o_word_last  = 1'b1;
        o_word       = count_ext[OUT_WIDTH-1:0];
      end
`endif
      default: ;
    endcase

    if (drop) o_word_valid = 1'b0;
    hs = o_word_valid & i_word_ready;

    acc_base  = hs ? (acc << OUT_WIDTH) : acc;
    fill_base = hs ? (full ? fill - OW : 7'd0) : fill;
    acc_nx    = acc_base;
    fill_nx   = fill_base;

    case (state)
      S_WAIT: begin
        if (i_rank_done) state_nx = S_ACCEPT;
      end
      S_ACCEPT: begin
        o_data_ready = !flush_pending;
        if (flush_pending) begin
          state_nx = S_FLUSH;
          flush_nx = i_flush;
        end else if (i_data_valid) begin
          query_nx = i_data;
          state_nx = S_LOOKUP;
        end
      end
      S_LOOKUP: state_nx = S_CAPTURE;
      S_CAPTURE: begin
        // A concurrent word handshake frees room, so the code lands after the shift.
        append = (fill < OW) | hs;
        if (append) begin
          acc_nx       = acc_base | (code_al >> fill_base);
          fill_nx      = fill_base + 7'(code_len);
          o_data_ready = !flush_pending;
`ifdef ALIB_RANK_ENC_COUNT_EN
          if (count != 32'hFFFF_FFFF) count_nx = count + 32'd1;
`endif
          if (o_data_ready && i_data_valid) begin
            query_nx = i_data;
            state_nx = S_LOOKUP;
          end else begin
            state_nx = S_ACCEPT;
          end
        end
      end
      S_FLUSH: begin
        if (hs && !full) begin
          acc_nx  = '0;
          fill_nx = 7'd0;
`ifdef ALIB_RANK_ENC_COUNT_EN
          state_nx = S_TRAILER;
`else
          state_nx = S_ACCEPT;
`endif
        end
      end
`ifdef ALIB_RANK_ENC_COUNT_EN
      S_TRAILER: begin
        if (hs) begin
          count_nx = 32'd0;
          state_nx = S_ACCEPT;
        end
      end
`endif
      default: state_nx = S_WAIT;
    endcase

    if (drop) begin
      o_data_ready = 1'b0;
      state_nx     = S_WAIT;
      acc_nx       = '0;
      fill_nx      = 7'd0;
      flush_nx     = 1'b0;
      abort_nx     = 1'b1;
`ifdef ALIB_RANK_ENC_COUNT_EN
      count_nx     = 32'd0;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= S_WAIT;
      acc           <= '0;
      fill          <= 7'd0;
      flush_pending <= 1'b0;
      o_query_char  <= 8'd0;
      o_abort       <= 1'b0;
`ifdef ALIB_RANK_ENC_COUNT_EN
      count         <= 32'd0;
`endif
    end else begin
      state         <= state_nx;
      acc           <= acc_nx;
      fill          <= fill_nx;
      flush_pending <= flush_nx;
      o_query_char  <= query_nx;
      o_abort       <= abort_nx;
`ifdef ALIB_RANK_ENC_COUNT_EN
      count         <= count_nx;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alib_rank_symbol_encoder.sv
// Testbench for alib_rank_symbol_encoder: directed vector table, corner sequences and randomized blocks vs. a bit-queue model.
`default_nettype none

module tb_alib_rank_symbol_encoder;

  localparam int OW = 32;
  localparam int SB = 4;
`ifdef ALIB_RANK_ENC_COUNT_EN
  localparam bit LASTPAD = 1'b0;
`else
  localparam bit LASTPAD = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          i_rst = 1'b0;
  logic [7:0]    i_data = 8'd0;
  logic          i_data_valid = 1'b0;
  logic          o_data_ready;
  logic          i_flush = 1'b0;
  logic          i_rank_done = 1'b0;
  logic [7:0]    o_query_char;
  logic [7:0]    qrank = 8'd0;
  logic [OW-1:0] o_word;
  logic          o_word_valid;
  logic          i_word_ready = 1'b0;
  logic [6:0]    o_word_bits;
  logic          o_word_last;
  logic          o_abort;

  always #5 clk = ~clk;

  alib_rank_symbol_encoder #(.OUT_WIDTH(OW), .SHORT_BITS(SB)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready), .i_flush(i_flush), .i_rank_done(i_rank_done),
    .o_query_char(o_query_char), .i_query_rank(qrank), .o_word(o_word),
    .o_word_valid(o_word_valid), .i_word_ready(i_word_ready), .o_word_bits(o_word_bits),
    .o_word_last(o_word_last), .o_abort(o_abort)
  );

  // Frequency table model: rank registered one cycle after the query char.
  logic [7:0] rank_tab [256];
  always @(posedge clk) qrank <= rank_tab[o_query_char];

  typedef struct { logic [31:0] w; int b; bit l; } word_t;
  typedef struct {
    int n; logic [63:0] ranks; int nw;
    logic [31:0] w0; int b0; bit l0; logic [31:0] w1; int b1; bit l1;
  } vec_t;

  word_t      obs[$], exp_q[$], held;
  logic [7:0] blk[$];
  vec_t       vt[6];
  int         errors = 0, checks = 0;
  bit         hold = 0, rand_ready = 0, prev_stall = 0, saw_ready_low = 0;

  function automatic word_t mkw(input logic [31:0] w, input int b, input bit l);
    word_t e; e.w = w; e.b = b; e.l = l; return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  always @(negedge clk)
    i_word_ready = hold ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);

  always @(negedge clk) begin
    #2;
    if (i_rst && o_word_valid) begin
      if (prev_stall) begin
        chk("stable_word", o_word, held.w);
        chk("stable_bits", o_word_bits, held.b);
        chk("stable_last", o_word_last, held.l);
      end
      if (hold && !o_data_ready) saw_ready_low = 1;
      if (i_word_ready) obs.push_back(mkw(o_word, int'(o_word_bits), o_word_last));
      prev_stall = !i_word_ready;
      held = mkw(o_word, int'(o_word_bits), o_word_last);
    end else begin
      prev_stall = 0;
    end
  end

  // Reference: concatenate prefix codes as a bit queue, then slice into words.
  task automatic build_exp();
    bit q[$];
    int r, len, val, n;
    logic [31:0] w;
    foreach (blk[i]) begin
      r = int'(rank_tab[blk[i]]);
      if (r < (1 << SB)) begin len = SB + 1; val = r; end
      else begin len = 9; val = 256 + r; end
      for (int k = len - 1; k >= 0; k--) q.push_back(val[k]);
    end
    while (q.size() >= OW) begin
      w = 0;
      for (int k = 0; k < OW; k++) w = {w[30:0], q.pop_front()};
      exp_q.push_back(mkw(w, OW, 1'b0));
    end
    n = q.size();
    w = 0;
    for (int k = 0; k < OW; k++) w = {w[30:0], (k < n) ? q.pop_front() : 1'b0};
    exp_q.push_back(mkw(w, n, LASTPAD));
`ifdef ALIB_RANK_ENC_COUNT_EN
    exp_q.push_back(mkw(32'(blk.size()), OW, 1'b1));
`endif
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    i_data = b; i_data_valid = 1'b1;
    #1;
    while (!o_data_ready && t < 300) begin @(negedge clk); #1; t++; end
    if (!o_data_ready) begin
      checks++; errors++;
      $display("FAIL data_ready_timeout: ready=%0d required 1", o_data_ready);
    end
    @(negedge clk);
    i_data_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk); i_flush = 1'b1;
    @(negedge clk); i_flush = 1'b0;
  endtask

  task automatic send_blk(input bit gaps);
    foreach (blk[i]) begin
      send_byte(blk[i]);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic compare_all(input string name);
    int t = 0;
    while (obs.size() < exp_q.size() && t < 3000) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    chk({name, "_count"}, obs.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < obs.size()) begin
        chk({name, "_word"}, obs[i].w, exp_q[i].w);
        chk({name, "_bits"}, obs[i].b, exp_q[i].b);
        chk({name, "_last"}, obs[i].l, exp_q[i].l);
      end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_ready"}, o_data_ready, 0);
    chk({name, "_query"}, o_query_char, 0);
    chk({name, "_word"}, o_word, 0);
    chk({name, "_valid"}, o_word_valid, 0);
    chk({name, "_bits"}, o_word_bits, 0);
    chk({name, "_last"}, o_word_last, 0);
    chk({name, "_abort"}, o_abort, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{2, 64'h000000000000C803, 1, 32'h1F200000, 14, LASTPAD, 32'h0, 0, 1'b0};
    vt[1] = '{7, 64'h000F0F0F0F0F0F0F, 2, 32'h7BDEF7BD, 32, 1'b0, 32'hE0000000, 3, LASTPAD};
    vt[2] = '{0, 64'h0, 1, 32'h00000000, 0, LASTPAD, 32'h0, 0, 1'b0};
    vt[3] = '{1, 64'h0, 1, 32'h00000000, 5, LASTPAD, 32'h0, 0, 1'b0};
    vt[4] = '{1, 64'h10, 1, 32'h88000000, 9, LASTPAD, 32'h0, 0, 1'b0};
    vt[5] = '{4, 64'h00000000FFFFFFFF, 2, 32'hFFFFFFFF, 32, 1'b0, 32'hF0000000, 4, LASTPAD};
    for (int c = 0; c < 256; c++) rank_tab[c] = 8'(c);

    repeat (2) @(negedge clk);
    #1 check_idle_outputs("reset");
    @(negedge clk); i_rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("wait_table_ready", o_data_ready, 0);
    @(negedge clk); i_rank_done = 1'b1;
    @(negedge clk);
    #1 chk("accept_ready", o_data_ready, 1);

    foreach (vt[v]) begin
      blk.delete();
      for (int i = 0; i < vt[v].n; i++) blk.push_back(vt[v].ranks[8*i +: 8]);
      exp_q.push_back(mkw(vt[v].w0, vt[v].b0, vt[v].l0));
      if (vt[v].nw > 1) exp_q.push_back(mkw(vt[v].w1, vt[v].b1, vt[v].l1));
`ifdef ALIB_RANK_ENC_COUNT_EN
      exp_q.push_back(mkw(32'(vt[v].n), OW, 1'b1));
`endif
      send_blk(1'b0);
      do_flush();
      compare_all("vec");
    end

    // Output backpressure for 20 cycles while streaming long codes.
    blk.delete();
    for (int i = 0; i < 12; i++) blk.push_back(8'($urandom_range(16, 255)));
    build_exp();
    saw_ready_low = 0;
    fork
      begin hold = 1; repeat (20) @(negedge clk); hold = 0; end
      send_blk(1'b0);
    join
    do_flush();
    compare_all("stall");
    chk("stall_ready_low", saw_ready_low, 1);

    // Table drop while a byte waits in CAPTURE.
    hold = 1;
    blk.delete();
    repeat (5) blk.push_back(8'hFF);
    send_blk(1'b0);
    repeat (3) @(negedge clk);
    i_rank_done = 1'b0;
    #1 chk("drop_valid_now", o_word_valid, 0);
    @(negedge clk);
    #1 chk("abort_pulse", o_abort, 1);
    chk("abort_valid", o_word_valid, 0);
    chk("abort_ready", o_data_ready, 0);
    @(negedge clk);
    #1 chk("abort_one_cycle", o_abort, 0);
    @(negedge clk); i_rank_done = 1'b1; hold = 0;
    obs.delete();
    blk.delete(); blk.push_back(8'd3); blk.push_back(8'd200);
    build_exp();
    send_blk(1'b0);
    do_flush();
    compare_all("after_abort");

    // Asynchronous reset mid-block.
    hold = 1;
    blk.delete();
    repeat (5) blk.push_back(8'hFF);
    send_blk(1'b0);
    repeat (2) @(negedge clk);
    #3 i_rst = 1'b0; i_rank_done = 1'b0;
    #1 check_idle_outputs("async_reset");
    @(negedge clk); i_rst = 1'b1; hold = 0;
    repeat (3) @(negedge clk);
    #1 chk("post_reset_ready", o_data_ready, 0);
    @(negedge clk); i_rank_done = 1'b1;
    @(negedge clk);
    #1 chk("post_reset_accept", o_data_ready, 1);
    obs.delete();

    // Randomized blocks against the model with random table and sink readiness.
    for (int c = 0; c < 256; c++) rank_tab[c] = 8'($urandom_range(0, 255));
    rand_ready = 1;
    for (int b = 0; b < 8; b++) begin
      blk.delete();
      repeat ($urandom_range(0, 24)) blk.push_back(8'($urandom_range(0, 255)));
      build_exp();
      send_blk(1'b1);
      do_flush();
      compare_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
